// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor with an optional accumulator operand.
//
// state | meaning
// IDLE  | waiting for a request; accumulator clear honoured here
// RUN   | one DIGIT-bit ripple slice per cycle, LSB slice first
// DONE  | result held until the consumer takes it
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_addsub: DIGIT must be >= 1 and divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic             acc_en_q;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [DIGIT-1:0] slice_sum;
  logic [DIGIT:0]   c;

  // Ripple one slice of the shifted operands; c[DIGIT-1] is the carry into the
  // slice MSB, which on the final slice is the carry into bit WIDTH-1.
  always_comb begin
    c         = '0;
    slice_sum = '0;
    c[0]      = carry;
    for (int i = 0; i < DIGIT; i++) begin
      slice_sum[i] = op_a[i] ^ op_b[i] ^ c[i];
      c[i+1]       = (op_a[i] & op_b[i]) | (c[i] & (op_a[i] ^ op_b[i]));
    end
  end

  // Result shifts in from the top so it is aligned after N slices.
  assign res_next = (res >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));
  assign last     = (cnt == CW'(N - 1));

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);

  // Control FSM, operand shifters, result and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      res      <= '0;
      acc      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      carry    <= 1'b0;
      acc_en_q <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_clr) acc <= '0;
          if (in_valid) begin
            // A clear coinciding with an accumulate uses the cleared value.
            op_a     <= acc_en ? (acc_clr ? '0 : acc) : a;
            op_b     <= sub ? ~b : b;
            carry    <= sub | cin;
            acc_en_q <= acc_en;
            cnt      <= '0;
            res      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          op_a  <= op_a >> DIGIT;
          op_b  <= op_b >> DIGIT;
          carry <= c[DIGIT];
          res   <= res_next;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum   <= res_next;
            cout  <= c[DIGIT];
            ovf   <= c[DIGIT] ^ c[DIGIT-1];
            if (acc_en_q) acc <= res_next;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub, WIDTH=8, DIGIT=2 (four slices per op).
module tb_serial_addsub;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       acc_en;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  serial_addsub #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .ovf(ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request, take the accept edge, then scramble every input so a
  // design that re-samples them during RUN produces a wrong result.
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                          input logic tsub, input logic tacc_en, input logic tacc_clr);
    a = ta; b = tb_v; cin = tcin; sub = tsub; acc_en = tacc_en; acc_clr = tacc_clr;
    in_valid = 1'b1;
    check("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    a = ~ta; b = ~tb_v; cin = ~tcin; sub = ~tsub; acc_en = ~tacc_en; acc_clr = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
  endtask

  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic tcin, input logic tsub, input logic tacc_en,
                       input logic tacc_clr, input logic [7:0] es, input logic ec,
                       input logic eo);
    start_op(ta, tb_v, tcin, tsub, tacc_en, tacc_clr);
    wait_done(tag);
    check({tag, "_sum"},  32'(sum),  32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"},  32'(ovf),  32'(eo));
    in_valid = 1'b0; acc_clr = 1'b0; acc_en = 1'b0;
    @(posedge clk); #1;
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int j;
    logic seen;
    rst = 1'b1; in_valid = 0; a = 0; b = 0; cin = 0; sub = 0;
    acc_en = 0; acc_clr = 0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_acc",       32'(dut.acc),   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // name, a, b, cin, sub, acc_en, acc_clr, sum, cout, ovf
    do_op("add_3_5",   8'h03, 8'h05, 0, 0, 0, 0, 8'h08, 0, 0);
    do_op("add_ff_1",  8'hFF, 8'h01, 0, 0, 0, 0, 8'h00, 1, 0);
    do_op("add_7f_1",  8'h7F, 8'h01, 0, 0, 0, 0, 8'h80, 0, 1);
    do_op("add_7f_c",  8'h7F, 8'h00, 1, 0, 0, 0, 8'h80, 0, 1);
    do_op("add_f_1c",  8'h0F, 8'h01, 1, 0, 0, 0, 8'h11, 0, 0);
    do_op("sub_5_7",   8'h05, 8'h07, 1, 1, 0, 0, 8'hFE, 0, 0);
    do_op("sub_80_1",  8'h80, 8'h01, 0, 1, 0, 0, 8'h7F, 1, 1);
    do_op("sub_eq",    8'h10, 8'h10, 0, 1, 0, 0, 8'h00, 1, 0);

    // Accumulator: preload, clear alone, three adds, clear-with-accept.
    do_op("acc_pre",   8'h00, 8'h77, 0, 0, 1, 0, 8'h77, 0, 0);
    check("acc_pre_val", 32'(dut.acc), 32'h77);
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    check("acc_cleared", 32'(dut.acc), 32'd0);
    do_op("acc_1",     8'h55, 8'h10, 0, 0, 1, 0, 8'h10, 0, 0);
    do_op("acc_2",     8'h55, 8'h10, 0, 0, 1, 0, 8'h20, 0, 0);
    do_op("acc_3",     8'h55, 8'h10, 0, 0, 1, 0, 8'h30, 0, 0);
    do_op("acc_clr_en", 8'h55, 8'h05, 0, 0, 1, 1, 8'h05, 0, 0);
    check("acc_final", 32'(dut.acc), 32'h05);

    // Backpressure in DONE with new requests and clears presented.
    out_ready = 1'b0;
    start_op(8'h21, 8'h12, 0, 0, 0, 0);
    wait_done("bp");
    check("bp_sum0", 32'(sum), 32'h33);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'hAA; b = 8'h55; acc_clr = 1'b1;
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sum",   32'(sum),       32'h33);
      check("bp_ready", 32'(in_ready),  32'd0);
    end
    in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready),  32'd1);
    check("bp_release_busy",  32'(busy),      32'd0);
    check("bp_acc_kept",      32'(dut.acc),   32'h05);

    // Throughput with in_valid held: one result every N+2 = 6 cycles.
    in_valid = 1'b1; a = 8'h01; b = 8'h01; cin = 0; sub = 0; acc_en = 0; acc_clr = 0;
    j = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        j = k;
        break;
      end
    end
    check("tp_first", 32'(j), 32'd5);
    j = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        j = k;
        break;
      end
    end
    check("tp_period", 32'(j), 32'd6);
    check("tp_sum", 32'(sum), 32'h02);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset two slices into an accumulate operation.
    start_op(8'h00, 8'h20, 0, 0, 1, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_cnt", 32'(dut.cnt), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy",  32'(busy),      32'd0);
    check("mid_rst_sum",   32'(sum),       32'd0);
    check("mid_rst_acc",   32'(dut.acc),   32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd0);
    rst = 1'b0; in_valid = 1'b0; acc_clr = 1'b0; acc_en = 1'b0;
    @(posedge clk); #1;
    check("mid_post_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("mid_no_result", 32'(seen), 32'd0);
    do_op("recover",   8'h0F, 8'h01, 1, 0, 0, 0, 8'h11, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width in bits.
REQ-002 SHALL provide parameter DIGIT, default 2, bits processed per clock; WIDTH % DIGIT == 0 and DIGIT >= 1 are elaboration checks.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand request.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in for add.
REQ-011 sub  input  1  1 = subtract (A - B), 0 = add.
REQ-012 acc_en  input  1  1 = use accumulator in place of A and write the result back to it.
REQ-013 acc_clr  input  1  clears the accumulator; honoured in IDLE only.
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 sum  output  WIDTH  result.
REQ-017 cout  output  1  carry out of the MSB.
REQ-018 ovf  output  1  signed two's-complement overflow.
REQ-019 busy  output  1  high in RUN.

Function
REQ-020 FSM states SHALL be IDLE, RUN, DONE; in_ready = 1 only in IDLE, out_valid = 1 only in DONE, busy = 1 only in RUN.
REQ-021 Accept SHALL occur on an edge with in_valid & in_ready: register a (or acc if acc_en), b, cin, sub, acc_en; set digit counter 0; go to RUN.
REQ-022 Operand B SHALL be bitwise inverted and carry-in forced to 1 when sub = 1 (cin ignored); else carry-in = cin.
REQ-023 RUN SHALL compute one DIGIT-bit ripple slice per cycle, LSB slice first, carrying the registered carry between slices.
REQ-024 RUN SHALL last exactly N = WIDTH/DIGIT cycles; out_valid rises N edges after the accept edge.
REQ-025 sum = (A + B' + c0) mod 2^WIDTH; cout = carry out of bit WIDTH-1; ovf = carry into bit WIDTH-1 XOR cout.
REQ-026 For sub = 1, cout = 1 SHALL mean no borrow (A >= B unsigned).
REQ-027 On entering DONE with registered acc_en = 1, the accumulator SHALL be loaded with sum on the same edge.
REQ-028 In DONE, sum/cout/ovf SHALL hold stable until out_valid & out_ready; on that edge go to IDLE.
REQ-029 in_valid SHALL be ignored outside IDLE; inputs changing during RUN/DONE SHALL not affect the result.
REQ-030 acc_clr in IDLE SHALL zero the accumulator on that edge; if acc_clr and an accept with acc_en coincide, A SHALL be 0 (clear wins, cleared value used).
REQ-031 acc_clr in RUN or DONE SHALL be ignored.
REQ-032 Back-to-back throughput SHALL be one result per N+2 cycles when out_ready is held high (one DONE cycle, one IDLE cycle).

Reset
REQ-033 While rst = 1 on an edge: state IDLE, out_valid 0, busy 0, sum 0, cout 0, ovf 0, accumulator 0, digit counter 0.
REQ-034 in_ready SHALL be 0 during any cycle rst is high and 1 the cycle after rst deasserts.
REQ-035 rst during RUN or DONE SHALL abort the operation with no result delivered and no accumulator update.

Verification (WIDTH=8, DIGIT=2, N=4)
REQ-036 Add: a=0x03,b=0x05,cin=0 accepted at edge E -> out_valid at E+4, sum=0x08, cout=0, ovf=0.
REQ-037 Wrap/overflow: 0xFF+0x01 -> sum=0x00, cout=1, ovf=0; 0x7F+0x01 -> sum=0x80, cout=0, ovf=1; 0x7F+0x00, cin=1 -> sum=0x80, ovf=1.
REQ-038 Subtract: a=0x05,b=0x07,sub=1,cin=1 -> sum=0xFE, cout=0, ovf=0; a=0x80,b=0x01 -> sum=0x7F, cout=1, ovf=1.
REQ-039 Accumulate: acc_clr, then three acc_en adds of b=0x10 -> sums 0x10,0x20,0x30; then acc_clr coincident with acc_en accept of b=0x05 -> sum 0x05.
REQ-040 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and sum stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-041 Reset mid-RUN at digit 2 -> next cycle out_valid=0, busy=0, sum=0, accumulator=0; in_ready=1 one cycle after rst drops.
